vga_pixel_out: RTL

- Display-side end of the renderer interface: generates the DrawX/DrawY scan coordinates that the frogger renderer consumes.
- Takes back the renderer's 6-bit colorcode, maps it through the game palette to 24-bit RGB, and drives VGA sync/blank with all outputs aligned.
- Sits between the renderer and the board VGA DAC.
- Also emits a once-per-frame strobe used by game logic (sprite motion, time bar).

---
 rtl/vga_pixel_out.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vga_pixel_out.sv
// VGA scan timing, palette lookup and sync/blank output stage for the frogger renderer.
// Optional `VGA_TEST_PATTERN_EN adds a test_mode input that replaces colorcode with DrawX[9:6] bars.
module vga_pixel_out #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] colorcode,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_CLK,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hc_q, hc_d, vc_q, vc_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;

    logic             pix_en, lineEnd, frameEnd, visible, hsActive, vsActive;
    logic [5:0]       palIdx;
    logic [23:0]      palRgb;

    assign pix_en   = (div_q == DIV_W'(CLK_DIV - 1));
    assign lineEnd  = (hc_q == 10'(H_TOTAL - 1));
    assign frameEnd = lineEnd && (vc_q == 10'(V_TOTAL - 1));

    always_comb begin
        div_d = pix_en ? '0 : div_q + DIV_W'(1);
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (pix_en) begin
            if (lineEnd) begin
                hc_d = '0;
                vc_d = (vc_q == 10'(V_TOTAL - 1)) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    assign palIdx = test_mode ? {2'b00, hc_q[9:6]} : colorcode;
`else
    assign palIdx = colorcode;
`endif

    always_comb begin
        case (palIdx)
            6'd0:    palRgb = 24'hFFFFFF;
            6'd1:    palRgb = 24'h000000;
            6'd2:    palRgb = 24'h27B212;
            6'd3:    palRgb = 24'hD80222;
            6'd4:    palRgb = 24'h5DB1F0;
            6'd5:    palRgb = 24'hF1FF0A;
            6'd6:    palRgb = 24'hB2B2B0;
            6'd7:    palRgb = 24'hF27A00;
            6'd8:    palRgb = 24'h663300;
            6'd9:    palRgb = 24'h8600B3;
            6'd10:   palRgb = 24'h000066;
            6'd11:   palRgb = 24'hFFFFFF;
            6'd12:   palRgb = 24'h70F248;
            default: palRgb = 24'h000000;
        endcase
    end

    assign visible  = (hc_q < 10'(H_VISIBLE)) && (vc_q < 10'(V_VISIBLE));
    assign hsActive = (hc_q >= 10'(H_VISIBLE + H_FRONT)) && (hc_q < 10'(H_VISIBLE + H_FRONT + H_SYNC));
    assign vsActive = (vc_q >= 10'(V_VISIBLE + V_FRONT)) && (vc_q < 10'(V_VISIBLE + V_FRONT + V_SYNC));

    // Output stage captures the pixel being scanned now, giving every output the same one-pixel lag.
    always_comb begin
        rgb_d   = rgb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        fs_d    = pix_en && frameEnd;
        if (pix_en) begin
            rgb_d   = visible ? palRgb : 24'h000000;
            hs_d    = ~hsActive;
            vs_d    = ~vsActive;
            blank_d = visible;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_CLK     = (div_q >= DIV_W'(CLK_DIV / 2));
    assign frame_start = fs_q;
endmodule
